// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pixel pipeline.
// Holds the default pixel width and feature-map size, and the pooling stage FSM encoding.
package cnn_pkg;

    localparam int unsigned DataWDefault = 8;
    localparam int unsigned InDimDefault = 26;

    typedef enum logic [1:0] {
        StIdle,
        StEvenRow,
        StOddRow,
        StDone
    } pool_state_e;

endpackage

// File: rtl/pool_line_buffer.sv
// Line buffer for the pooling stage. It holds one pair-maximum per column pair of the even row.
// There is no reset, because every entry is rewritten on the even row before the odd row reads it.
// Ports:
//   clk_i   - clock; writes happen on the rising edge
//   we_i    - write enable
//   waddr_i - write address (column pair index)
//   wdata_i - write data
//   raddr_i - read address; the read is combinational
//   rdata_o - read data
module pool_line_buffer
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned DEPTH  = InDimDefault / 2,
    parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool_stage.sv
// 2x2, stride-2 max pooling over a raster-order IN_DIM x IN_DIM feature map.
// On each even row, the maximum of every column pair is stored in the line buffer.
// On each odd row, the pair maximum is combined with the stored value and emitted one cycle later.
// Ports:
//   clk_i         - clock
//   rst_ni        - asynchronous active-low reset
//   clear_i       - synchronous restart; drops the current image and returns to idle
//   pixel_i       - input pixel, unsigned, in raster order
//   pixel_valid_i - qualifies pixel_i; gaps are allowed and there is no backpressure
//   pixel_o       - pooled pixel; holds its value between strobes
//   pixel_valid_o - single-cycle strobe that qualifies pixel_o
//   image_done_o  - level; high after the last pooled pixel of the image
//   overrun_o     - sticky; set when a pixel arrives after the image is complete
module maxpool_stage
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned IN_DIM = InDimDefault
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] pixel_i,
    input  logic              pixel_valid_i,
    output logic [DATA_W-1:0] pixel_o,
    output logic              pixel_valid_o,
    output logic              image_done_o,
    output logic              overrun_o
);

    localparam int unsigned Half = IN_DIM / 2;
    localparam int unsigned CW   = (IN_DIM > 2) ? $clog2(IN_DIM) : 1;
    localparam int unsigned AW   = (Half > 1) ? $clog2(Half) : 1;
    localparam logic [CW-1:0] LastIdx = CW'(IN_DIM - 1);

    if (((IN_DIM % 2) != 0) || (IN_DIM < 2)) begin : gen_dim_check
        $error("maxpool_stage: IN_DIM must be even and at least 2");
    end

    pool_state_e       state_q, state_d;
    logic [CW-1:0]     col_q, row_q;
    logic [DATA_W-1:0] hold_q, pixel_q;
    logic              valid_q, done_q, overrun_q;

    logic              accept, col_last, row_last, odd_col, odd_row, lb_we;
    logic [AW-1:0]     lb_addr;
    logic [DATA_W-1:0] pair_max, pool_max, lb_rdata;

    assign accept   = pixel_valid_i && (state_q != StDone);
    assign col_last = (col_q == LastIdx);
    assign row_last = (row_q == LastIdx);
    assign odd_col  = col_q[0];
    assign odd_row  = row_q[0];
    assign lb_addr  = AW'(col_q >> 1);
    assign lb_we    = accept && odd_col && !odd_row && !clear_i;
    assign pair_max = (pixel_i > hold_q) ? pixel_i : hold_q;
    assign pool_max = (lb_rdata > pair_max) ? lb_rdata : pair_max;

    pool_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (Half),
        .AW     (AW)
    ) u_line_buffer (
        .clk_i   (clk_i),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (pair_max),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pixel_valid_i) state_d = StEvenRow;
                end
                StEvenRow: begin
                    if (pixel_valid_i && col_last) state_d = StOddRow;
                end
                StOddRow: begin
                    if (pixel_valid_i && col_last) state_d = row_last ? StDone : StEvenRow;
                end
                StDone: state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q     <= '0;
            row_q     <= '0;
            hold_q    <= '0;
            pixel_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else if (clear_i) begin
            // pixel_q is kept so the output holds its last value.
            col_q     <= '0;
            row_q     <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (pixel_valid_i && (state_q == StDone)) begin
                overrun_q <= 1'b1;
            end
            if (accept) begin
                if (!odd_col) begin
                    hold_q <= pixel_i;
                end else if (odd_row) begin
                    pixel_q <= pool_max;
                    valid_q <= 1'b1;
                    if (row_last && col_last) done_q <= 1'b1;
                end
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign pixel_o       = pixel_q;
    assign pixel_valid_o = valid_q;
    assign image_done_o  = done_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_maxpool_stage.sv
// Directed bench for maxpool_stage. Expected pooled values come from the bench's own image array.
// They are pushed when the completing pixel is driven and popped when the DUT strobes.
module tb_maxpool_stage;

    localparam int DW   = 8;
    localparam int DIM  = 26;
    localparam int HALF = DIM / 2;
    localparam int NOUT = HALF * HALF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] pix = '0;
    logic          pvalid = 1'b0;
    logic [DW-1:0] pix_o;
    logic          pvalid_o, done_o, ovr_o;

    maxpool_stage #(
        .DATA_W (DW),
        .IN_DIM (DIM)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .pixel_i       (pix),
        .pixel_valid_i (pvalid),
        .pixel_o       (pix_o),
        .pixel_valid_o (pvalid_o),
        .image_done_o  (done_o),
        .overrun_o     (ovr_o)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] img [DIM][DIM];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] out_img [NOUT];
    logic [DW-1:0] ramp_out [NOUT];
    int            n_out = 0;
    bit            mon_en = 1'b0;
    logic          completing = 1'b0;
    logic          last_px = 1'b0;
    logic          cap_complete = 1'b0;
    logic          cap_last = 1'b0;
    logic          exp_done = 1'b0;

    // Reference timing: a strobe is owed in the cycle after a completing pixel is captured.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_complete <= 1'b0;
            cap_last     <= 1'b0;
            exp_done     <= 1'b0;
        end else begin
            cap_complete <= pvalid && completing && !clear;
            cap_last     <= pvalid && last_px && !clear;
            if (clear) exp_done <= 1'b0;
            else if (pvalid && last_px) exp_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            assert (pvalid_o === cap_complete) else begin
                fails++;
                $error("FAIL strobe: observed %b expected %b", pvalid_o, cap_complete);
            end
            tests++;
            assert (done_o === exp_done) else begin
                fails++;
                $error("FAIL image_done: observed %b expected %b", done_o, exp_done);
            end
            if (pvalid_o === 1'b1) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_out: observed %0d expected none", pix_o);
                end
                if (exp_q.size() != 0) begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    tests++;
                    assert (pix_o === e) else begin
                        fails++;
                        $error("FAIL pooled[%0d]: observed %0d expected %0d", n_out, pix_o, e);
                    end
                end
                if (n_out < NOUT) out_img[n_out] = pix_o;
                n_out++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [DW-1:0] max4(input int pr, input int pc);
        logic [DW-1:0] m;
        m = img[2*pr][2*pc];
        if (img[2*pr][2*pc+1] > m) m = img[2*pr][2*pc+1];
        if (img[2*pr+1][2*pc] > m) m = img[2*pr+1][2*pc];
        if (img[2*pr+1][2*pc+1] > m) m = img[2*pr+1][2*pc+1];
        return m;
    endfunction

    task automatic idle_cycle();
        @(posedge clk); #1;
        pvalid = 1'b0;
        completing = 1'b0;
        last_px = 1'b0;
        clear = 1'b0;
    endtask

    // Drive rows up to (but not including) stop_row, with 0..gap_max idle cycles before each pixel.
    task automatic send_img(input int gap_max, input int stop_row);
        for (int r = 0; r < DIM; r++) begin
            if (r == stop_row) break;
            for (int c = 0; c < DIM; c++) begin
                if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) idle_cycle();
                @(posedge clk); #1;
                pix = img[r][c];
                pvalid = 1'b1;
                completing = (r % 2 == 1) && (c % 2 == 1);
                last_px = (r == DIM - 1) && (c == DIM - 1);
                if (completing) exp_q.push_back(max4(r / 2, c / 2));
            end
        end
        idle_cycle();
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        idle_cycle();
        @(negedge clk); #1;
        check("clear_done", done_o, 0);
        check("clear_overrun", ovr_o, 0);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) img[r][c] = DW'((r * DIM + c) % 256);
    endtask

    task automatic compare_ramp(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < NOUT; i++) if (out_img[i] !== ramp_out[i]) mism++;
        check(tag, mism, 0);
    endtask

    initial begin
        #12;
        check("rst_pixel_o", pix_o, 0);
        check("rst_valid", pvalid_o, 0);
        check("rst_done", done_o, 0);
        check("rst_overrun", ovr_o, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Ramp image, continuous valid
        fill_ramp();
        n_out = 0;
        send_img(0, DIM);
        repeat (3) idle_cycle();
        @(negedge clk); #1;
        check("ramp_count", n_out, NOUT);
        check("ramp_out00", out_img[0], 27);
        check("ramp_out01", out_img[1], 29);
        check("ramp_out_r1c0", out_img[HALF], (3 * DIM + 1) % 256);
        check("ramp_done", done_o, 1);
        check("hold_pixel_o", pix_o, out_img[NOUT-1]);
        for (int i = 0; i < NOUT; i++) ramp_out[i] = out_img[i];
        do_clear();

        // Single hot pixel
        for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) img[r][c] = '0;
        img[5][7] = 8'd200;
        n_out = 0;
        send_img(0, DIM);
        @(negedge clk); #1;
        check("hot_count", n_out, NOUT);
        check("hot_value", out_img[2 * HALF + 3], 200);
        begin
            int nz;
            nz = 0;
            for (int i = 0; i < NOUT; i++) if (out_img[i] != 0) nz++;
            check("hot_nonzero", nz, 1);
        end
        do_clear();

        // Ramp image with random valid gaps
        fill_ramp();
        n_out = 0;
        send_img(5, DIM);
        @(negedge clk); #1;
        check("gap_count", n_out, NOUT);
        compare_ramp("gap_vs_ramp");

        do_clear();

        // Random image with fixed corner blocks
        for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) img[r][c] = DW'($urandom);
        img[0][0] = 8'd10; img[0][1] = 8'd250; img[1][0] = 8'd3; img[1][1] = 8'd7;
        for (int r = DIM - 2; r < DIM; r++) for (int c = DIM - 2; c < DIM; c++) img[r][c] = 8'd255;
        n_out = 0;
        send_img(0, DIM);
        @(negedge clk); #1;
        check("rand_count", n_out, NOUT);
        check("corner_first", out_img[0], 250);
        check("corner_last", out_img[NOUT-1], 255);

        // Extra pixel after the image completes
        @(posedge clk); #1;
        pix = 8'd99;
        pvalid = 1'b1;
        idle_cycle();
        @(negedge clk); #1;
        check("overrun_set", ovr_o, 1);
        check("overrun_no_strobe", pvalid_o, 0);
        check("overrun_done_held", done_o, 1);
        check("overrun_pixel_held", pix_o, 255);
        do_clear();

        fill_ramp();
        n_out = 0;
        send_img(0, DIM);
        @(negedge clk); #1;
        check("post_clear_count", n_out, NOUT);
        compare_ramp("post_clear_ramp");
        do_clear();

        // Reset asserted partway through an image
        send_img(0, 11);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_pixel_o", pix_o, 0);
        check("midrst_valid", pvalid_o, 0);
        check("midrst_done", done_o, 0);
        exp_q.delete();
        @(negedge clk); #3;
        rst_n = 1'b1;
        n_out = 0;
        send_img(0, DIM);
        @(negedge clk); #1;
        check("midrst_count", n_out, NOUT);
        compare_ramp("midrst_ramp");
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/maxpool_stage.md
MAXPOOL_STAGE -- requirements
Module: maxpool_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of input and output pixels.
REQ-002 SHALL have parameter IN_DIM, default 26, side length of the square input feature map; must be even.
REQ-003 SHALL have port clk_i  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous restart; abandons the current image and returns to IDLE.
REQ-006 SHALL have port pixel_i  input  DATA_W  unsigned convolution output pixel, raster order.
REQ-007 SHALL have port pixel_valid_i  input  1  pixel_i valid this cycle; arbitrary gaps allowed, no backpressure.
REQ-008 SHALL have port pixel_o  output  DATA_W  pooled pixel, raster order of the (IN_DIM/2)x(IN_DIM/2) map.
REQ-009 SHALL have port pixel_valid_o  output  1  single-cycle strobe qualifying pixel_o.
REQ-010 SHALL have port image_done_o  output  1  level, high after the last pooled pixel of an image.
REQ-011 SHALL have port overrun_o  output  1  sticky; pixel_valid_i seen while in DONE.

Function
REQ-012 SHALL compute 2x2, stride-2, non-overlapping max pooling with unsigned comparison; ties select either operand (identical value).
REQ-013 SHALL track input column col (0..IN_DIM-1) and row (0..IN_DIM-1), advanced only on pixel_valid_i; col wraps to 0 and row increments at col==IN_DIM-1.
REQ-014 SHALL hold the first pixel of each column pair (even col) in a holding register.
REQ-015 SHALL, on even rows at odd col, write max(hold, pixel_i) into line-buffer entry col/2 (IN_DIM/2 entries of DATA_W).
REQ-016 SHALL, on odd rows at odd col, register max(max(hold, pixel_i), linebuf[col/2]) into pixel_o and pulse pixel_valid_o the following cycle (latency 1 cycle from the completing input pixel).
REQ-017 SHALL hold pixel_o at its last value when pixel_valid_o is low.
REQ-018 SHALL implement states IDLE, EVEN_ROW, ODD_ROW, DONE.
REQ-019 SHALL transition IDLE->EVEN_ROW on the first pixel_valid_i (pixel consumed as row 0 col 0).
REQ-020 SHALL transition EVEN_ROW->ODD_ROW and ODD_ROW->EVEN_ROW on the valid pixel with col==IN_DIM-1.
REQ-021 SHALL transition ODD_ROW->DONE on the valid pixel at row==IN_DIM-1, col==IN_DIM-1; image_done_o rises in the same cycle pixel_valid_o pulses for the final output.
REQ-022 SHALL stay in DONE, ignoring pixel_i, until clear_i; pixel_valid_i in DONE sets overrun_o.
REQ-023 SHALL, on clear_i (priority over pixel_valid_i in the same cycle), zero counters, drop image_done_o and overrun_o, go to IDLE; line-buffer contents need not be cleared.
REQ-024 SHALL emit exactly (IN_DIM/2)^2 pixel_valid_o strobes per image (169 at default).

Reset
REQ-025 SHALL, on rst_ni low, immediately set state IDLE, counters 0, hold register 0, pixel_o 0, pixel_valid_o 0, image_done_o 0, overrun_o 0.
REQ-026 SHALL, if reset is asserted mid-image, discard the partial image; the next valid pixel after release is row 0 col 0.
REQ-027 SHALL not require line-buffer reset; its stale values are never output before being rewritten.

Structure
REQ-028 SHALL take DATA_W, IN_DIM default and the state enum from shared package cnn_pkg.
REQ-029 SHALL place the line buffer in sub-module pool_line_buffer (write port, asynchronous read port, IN_DIM/2 entries).
REQ-030 SHALL elaborate-time check IN_DIM even and IN_DIM>=2.

Verification
REQ-031 Ramp image pixel=(row*26+col)%256, continuous valid -> 169 outputs, output (r,c) = ((2r+1)*26+2c+1)%256 except at wrap windows, image_done_o with 169th strobe.
REQ-032 Single hot pixel 200 at (5,7), rest 0 -> output (2,3)=200, all other 168 outputs 0.
REQ-033 Same image with random valid gaps (0-5 idle cycles) -> outputs identical to REQ-031 run, each 1 cycle after the completing pixel.
REQ-034 Max in each quadrant corner: 2x2 block {10,250,3,7} -> 250; {255,255,255,255} -> 255.
REQ-035 rst_ni low at input row 11 then full image -> exactly 169 outputs matching the golden model, no stale data.
REQ-036 Extra valid pixel after DONE -> overrun_o=1, no pixel_valid_o; clear_i -> image_done_o=0, overrun_o=0, next image pools correctly.
